instr_encode_loader: RTL and testbench
======================================

Name: instr_encode_loader

Overview:
- Reverse direction of the core's opcode decoder: accepts field-level instruction requests (type, funct3, alt bit, rd, rs1, rs2, imm) and encodes them into RV32I 32-bit words.
- Buffers encoded words in a FIFO and streams them into instruction memory over a stall-able write port.
- Holds the single-cycle core in reset while loading; used for FPGA program load and verification stimulus.

Parameters:
- ADDR_W, 10, instruction-memory word-address width.
- MEM_WORDS, 1024, memory size in words; write address wraps at this value.
- FIFO_DEPTH, 4, encoded-word FIFO depth; power of 2, at least 2.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin load session; acted on in IDLE only.
- finish  in  1  end of request stream; acted on in LOAD only.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- in_type  in  4  0 R, 1 I, 2 IL, 3 S, 4 B, 5 U, 6 AUI, 7 J, 8 JALR, 9-15 illegal.
- in_funct3  in  3  funct3 field.
- in_alt  in  1  funct7[5] for R-type and for I-type shifts.
- in_rd, in_rs1, in_rs2  in  5 each  register fields.
- in_imm  in  32  byte-offset or immediate value; for U/AUI, upper value already in bits [31:12].
- mem_we  out  1  write request, registered.
- mem_addr  out  ADDR_W  word address, registered.
- mem_wdata  out  32  encoded instruction, registered.
- mem_stall  in  1  memory not accepting writes this cycle.
- cpu_hold  out  1  hold the core in reset.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at end of session.
- err  out  1  sticky error flag; cleared by start.
- count  out  ADDR_W+1  words written in the current session.

Behaviour:
- Reset (asynchronous): state IDLE; FIFO emptied; address 0; all outputs 0.
- Reset mid-session: discards FIFO contents and any pending write.

State machine, IDLE / LOAD / DRAIN:
- IDLE: start -> LOAD. On the same edge, clear address, count and err.
- LOAD: finish -> DRAIN.
- DRAIN: when FIFO is empty and no write is pending (mem_we=0), go to IDLE and pulse done.
- start outside IDLE is ignored. finish outside LOAD is ignored.
- cpu_hold = 1 in LOAD and DRAIN. It drops in the same cycle done pulses.

Input side:
- in_ready = (state==LOAD) && FIFO not full.
- An accepted beat is encoded combinationally and pushed into the FIFO at that edge.
- If in_valid && in_ready && finish occur together, the beat is accepted and the state moves to DRAIN.
- Illegal in_type: beat is accepted but not pushed; err is set.

Encoding, opcodes as the decoder expects:
- R: {0,alt,00000, rs2, rs1, f3, rd, 0110011}.
- I: {imm[11:0], rs1, f3, rd, 0010011}. When f3 is 001 or 101: bits [31:25] = {0,alt,00000} and bits [24:20] = imm[4:0].
- IL: {imm[11:0], rs1, f3, rd, 0000011}.
- JALR: {imm[11:0], rs1, 000, rd, 1100111}.
- S: {imm[11:5], rs2, rs1, f3, imm[4:0], 0100011}.
- B: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 1100011}.
- U: {imm[31:12], rd, 0110111}.
- AUI: {imm[31:12], rd, 0010111}.
- J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, 1101111}.

Write side:
- Pop condition: FIFO non-empty && (mem_we==0 || mem_stall==0).
- On pop: mem_we=1, mem_wdata=head, mem_addr=current address.
- A write completes on any cycle with mem_we=1 && mem_stall=0. On completion: address+1, count+1. With no new pop, mem_we goes to 0 on the next edge.
- While stalled, mem_we, mem_addr and mem_wdata hold.
- Minimum latency: accepted at edge N gives mem_we=1 after edge N+1. Throughput is 1 word/cycle with no stall.
- Address wrap: a write completing at MEM_WORDS-1 wraps the address to 0 and sets err.
- Simultaneous push and pop at FIFO full is legal; the occupancy does not change.

Optional Feature:
- Macro: LOADER_IMM_CHECK_EN.
- Defined: range-check in_imm on acceptance.
  - I/IL/S/JALR: signed 12-bit.
  - B: signed 13-bit and even.
  - J: signed 21-bit and even.
  - U/AUI: imm[11:0]==0.
  - I shifts: imm[11:5]==0.
  - On violation the beat is accepted but not pushed, and err is set.
- Undefined: no checks; immediates are truncated to the field bits as encoded.

Test Plan:
- start; push I addi rd1 rs1=0 imm5, then R add rd3 rs1=1 rs2=2, then R alt=1 (sub) with the same fields; finish -> mem writes 0x00500093 @0, 0x002081B3 @1, 0x402081B3 @2; done pulses once; count=3; cpu_hold falls with done.
- push S f3=010 rs1=1 rs2=2 imm8; push B f3=000 rs1=1 rs2=2 imm=-4 -> 0x0020A423, 0xFE208EE3.
- push J rd1 imm8; push U rd5 imm=0x12345000 -> 0x008000EF, 0x123452B7.
- hold mem_stall=1 for 6 cycles while pushing 6 beats -> in_ready drops after the FIFO fills; mem_addr and mem_wdata stable during the stall; after release all 6 words are written in order at addresses 0-5.
- push in_type=12 -> no write, err=1. A following start -> err=0, address 0.
- assert rst during DRAIN with 3 words queued -> all outputs 0 immediately; no further mem_we; no done.

Source files
------------

// File: rtl/instr_encode_loader.sv
// Encodes field-level RV32I requests into 32-bit words and streams them through a FIFO into instruction memory.
// Optional immediate range checking on acceptance is enabled by defining LOADER_IMM_CHECK_EN.
module instr_encode_loader #(
   parameter int unsigned ADDR_W     = 10,
   parameter int unsigned MEM_WORDS  = 1024,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              finish,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        in_type,
   input  logic [2:0]        in_funct3,
   input  logic              in_alt,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [31:0]       in_imm,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic              mem_stall,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   count
);
   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned OCC_W = PTR_W + 1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_WORDS - 1);

   localparam logic [3:0] T_R = 4'd0, T_I = 4'd1, T_IL = 4'd2, T_S = 4'd3, T_B = 4'd4;
   localparam logic [3:0] T_U = 4'd5, T_AUI = 4'd6, T_J = 4'd7, T_JALR = 4'd8;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN} state_t;

   state_t             state, state_next;
   logic               done_next;
   logic [31:0]        fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   rd_ptr, wr_ptr;
   logic [OCC_W-1:0]   occ;
   logic [ADDR_W-1:0]  addr, addr_after;
   logic [31:0]        enc_word;
   logic               enc_legal, imm_ok, is_shift;
   logic               fifo_empty, fifo_full, accept, push, bad_beat, pop, wr_done, addr_wrap, start_go;

   assign fifo_empty = (occ == '0);
   assign fifo_full  = (occ == OCC_W'(FIFO_DEPTH));
   assign in_ready   = (state == S_LOAD) && !fifo_full;
   assign accept     = in_valid && in_ready;
   assign push       = accept && enc_legal && imm_ok;
   assign bad_beat   = accept && !(enc_legal && imm_ok);
   assign pop        = !fifo_empty && (!mem_we || !mem_stall);
   assign wr_done    = mem_we && !mem_stall;
   assign addr_wrap  = wr_done && (addr == LAST_ADDR);
   assign start_go   = (state == S_IDLE) && start;
   assign is_shift   = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);

   // A new pop must target the address following any write completing this cycle
   assign addr_after = !wr_done ? addr : (addr_wrap ? '0 : addr + 1'b1);

   // Field packing mirrors the core's decoder opcode map
   always_comb begin
      enc_word  = '0;
      enc_legal = 1'b1;
      case (in_type)
         T_R:    enc_word = {1'b0, in_alt, 5'b0, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
         T_I:    if (is_shift) enc_word = {1'b0, in_alt, 5'b0, in_imm[4:0], in_rs1, in_funct3, in_rd, 7'b0010011};
                 else          enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
         T_IL:   enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0000011};
         T_JALR: enc_word = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b1100111};
         T_S:    enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], 7'b0100011};
         T_B:    enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3, in_imm[4:1], in_imm[11], 7'b1100011};
         T_U:    enc_word = {in_imm[31:12], in_rd, 7'b0110111};
         T_AUI:  enc_word = {in_imm[31:12], in_rd, 7'b0010111};
         T_J:    enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, 7'b1101111};
         default: enc_legal = 1'b0;
      endcase
   end

`ifdef LOADER_IMM_CHECK_EN
   logic s12, s13, s21;
   assign s12 = (&in_imm[31:11]) || !(|in_imm[31:11]);
   assign s13 = ((&in_imm[31:12]) || !(|in_imm[31:12])) && !in_imm[0];
   assign s21 = ((&in_imm[31:20]) || !(|in_imm[31:20])) && !in_imm[0];

   always_comb begin
      imm_ok = 1'b1;
      case (in_type)
         T_I:               imm_ok = is_shift ? (s12 && (in_imm[11:5] == 7'd0)) : s12;
         T_IL, T_S, T_JALR: imm_ok = s12;
         T_B:               imm_ok = s13;
         T_J:               imm_ok = s21;
         T_U, T_AUI:        imm_ok = (in_imm[11:0] == 12'd0);
         default:           imm_ok = 1'b1;
      endcase
   end
`else
   assign imm_ok = 1'b1;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      done_next  = 1'b0;
      case (state)
         S_IDLE:  if (start) state_next = S_LOAD;
         S_LOAD:  if (finish) state_next = S_DRAIN;
         S_DRAIN: if (fifo_empty && !mem_we) begin
                     state_next = S_IDLE;
                     done_next  = 1'b1;
                  end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= enc_word;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         occ       <= '0;
         addr      <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         cpu_hold  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         count     <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      occ <= occ + 1'b1;
         else if (pop && !push) occ <= occ - 1'b1;

         // Memory port holds its request while stalled
         if (pop) begin
            mem_we    <= 1'b1;
            mem_addr  <= addr_after;
            mem_wdata <= fifo_mem[rd_ptr];
         end else if (wr_done) begin
            mem_we    <= 1'b0;
         end

         if (start_go) begin
            addr  <= '0;
            count <= '0;
         end else if (wr_done) begin
            addr  <= addr_after;
            count <= count + 1'b1;
         end

         if (start_go)                   err <= 1'b0;
         else if (bad_beat || addr_wrap) err <= 1'b1;

         cpu_hold <= (state_next != S_IDLE);
         busy     <= (state_next != S_IDLE);
         done     <= done_next;
      end
   end
endmodule

// File: tb/tb_instr_encode_loader.sv
// Randomized self-checking bench for instr_encode_loader against a field-arithmetic encoding model.
module tb_instr_encode_loader;
   localparam int unsigned ADDR_W     = 10;
   localparam int unsigned MEM_WORDS  = 1024;
   localparam int unsigned FIFO_DEPTH = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0, finish = 1'b0, in_valid = 1'b0;
   logic              in_ready;
   logic [3:0]        in_type = '0;
   logic [2:0]        in_funct3 = '0;
   logic              in_alt = 1'b0;
   logic [4:0]        in_rd = '0, in_rs1 = '0, in_rs2 = '0;
   logic [31:0]       in_imm = '0;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              mem_stall = 1'b0;
   logic              cpu_hold, busy, done, err;
   logic [ADDR_W:0]   count;
   bit                stall_force = 1'b0, stall_rand = 1'b0;

   int checks = 0, errors = 0;
   int done_cnt = 0, hold_at_done = 0, we_cnt = 0;
   int obs_base = 0, done_base = 0, hold_base = 0;
   int model_addr = 0, model_count = 0;
   bit model_err = 1'b0;
   logic [ADDR_W-1:0] obs_addr[$], exp_addr[$];
   logic [31:0]       obs_data[$], exp_data[$];

   instr_encode_loader #(.ADDR_W(ADDR_W), .MEM_WORDS(MEM_WORDS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clk(clk), .rst(rst), .start(start), .finish(finish),
      .in_valid(in_valid), .in_ready(in_ready), .in_type(in_type), .in_funct3(in_funct3),
      .in_alt(in_alt), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_stall(mem_stall),
      .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err), .count(count));

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #2;
      mem_stall = stall_force || (stall_rand && ($urandom_range(0, 2) == 0));
   end

   // Memory-side observer: record completed writes and done pulses
   always @(negedge clk) begin
      if (!rst) begin
         if (mem_we && !mem_stall) begin
            obs_addr.push_back(mem_addr);
            obs_data.push_back(mem_wdata);
         end
         if (mem_we) we_cnt++;
         if (done) begin
            done_cnt++;
            if (cpu_hold) hold_at_done++;
         end
      end
   end

   // Reference encoder built from instruction-format field positions; bit 32 = legal type
   function automatic logic [32:0] ref_encode(input logic [3:0] t, input logic [2:0] f3, input logic alt,
         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
      logic [31:0] d, s1, s2, f, a, w;
      d  = 32'(rd) << 7;
      s1 = 32'(rs1) << 15;
      s2 = 32'(rs2) << 20;
      f  = 32'(f3) << 12;
      a  = 32'(alt) << 30;
      w  = 32'h0;
      case (t)
         4'd0: w = a | s2 | s1 | f | d | 32'h33;
         4'd1: if (f3 == 3'd1 || f3 == 3'd5) w = a | ((imm & 32'h1F) << 20) | s1 | f | d | 32'h13;
               else w = ((imm & 32'hFFF) << 20) | s1 | f | d | 32'h13;
         4'd2: w = ((imm & 32'hFFF) << 20) | s1 | f | d | 32'h03;
         4'd3: w = (((imm >> 5) & 32'h7F) << 25) | s2 | s1 | f | ((imm & 32'h1F) << 7) | 32'h23;
         4'd4: w = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | s2 | s1 | f
                   | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7) | 32'h63;
         4'd5: w = (imm & 32'hFFFFF000) | d | 32'h37;
         4'd6: w = (imm & 32'hFFFFF000) | d | 32'h17;
         4'd7: w = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 11) & 32'h1) << 20)
                   | (((imm >> 12) & 32'hFF) << 12) | d | 32'h6F;
         4'd8: w = ((imm & 32'hFFF) << 20) | s1 | d | 32'h67;
         default: return {1'b0, 32'h0};
      endcase
      return {1'b1, w};
   endfunction

   task automatic model_reset();
      model_addr  = 0;
      model_count = 0;
      model_err   = 1'b0;
      exp_addr.delete();
      exp_data.delete();
      obs_base  = obs_data.size();
      done_base = done_cnt;
      hold_base = hold_at_done;
   endtask

   task automatic do_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      model_reset();
   endtask

   // Offer one beat until accepted; optionally raise finish on the accepting cycle
   task automatic send_beat(input logic [3:0] t, input logic [2:0] f3, input logic alt, input logic [4:0] rd,
         input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm, input bit fin);
      bit ok = 1'b0;
      logic [32:0] r;
      in_type = t; in_funct3 = f3; in_alt = alt; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
      in_valid = 1'b1;
      for (int i = 0; i < 300 && !ok; i++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            if (fin) finish = 1'b1;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      finish   = 1'b0;
      if (!ok) begin
         checks++; errors++;
         $display("FAIL accept_timeout: beat type %0d never accepted, required acceptance", t);
      end else begin
         r = ref_encode(t, f3, alt, rd, rs1, rs2, imm);
         if (r[32]) begin
            exp_addr.push_back(ADDR_W'(model_addr));
            exp_data.push_back(r[31:0]);
            model_count++;
            if (model_addr == int'(MEM_WORDS) - 1) begin
               model_addr = 0;
               model_err  = 1'b1;
            end else begin
               model_addr++;
            end
         end else begin
            model_err = 1'b1;
         end
      end
   endtask

   task automatic finish_wait(input bit drive_finish);
      bit ok = 1'b0;
      if (drive_finish) begin
         finish = 1'b1;
         @(posedge clk); #1;
         finish = 1'b0;
      end
      for (int i = 0; i < 3000 && !ok; i++) begin
         @(negedge clk);
         if (done) ok = 1'b1;
      end
      @(posedge clk); #1;
      if (!ok) begin
         checks++; errors++;
         $display("FAIL done_timeout: done not seen, required one pulse");
      end
   endtask

   // Legal-range random beat so the same model holds with or without immediate checking
   task automatic rand_beat(input bit allow_illegal, output logic [3:0] t, output logic [2:0] f3, output logic alt,
         output logic [4:0] rd, output logic [4:0] rs1, output logic [4:0] rs2, output logic [31:0] imm);
      int v;
      t   = 4'($urandom_range(0, 8));
      f3  = 3'($urandom_range(0, 7));
      alt = 1'($urandom_range(0, 1));
      rd  = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
      case (t)
         4'd1: v = (f3 == 3'd1 || f3 == 3'd5) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 4095)) - 2048;
         4'd4: v = (int'($urandom_range(0, 4095)) - 2048) * 2;
         4'd7: v = (int'($urandom_range(0, 1048575)) - 524288) * 2;
         4'd5, 4'd6: v = int'($urandom & 32'hFFFFF000);
         default: v = int'($urandom_range(0, 4095)) - 2048;
      endcase
      imm = 32'(v);
      if (allow_illegal && $urandom_range(0, 9) == 0) t = 4'($urandom_range(9, 15));
   endtask

   task automatic test_reset();
      checks++; if (mem_we !== 1'b0)    begin errors++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
      checks++; if (mem_addr !== '0)    begin errors++; $display("FAIL rst_mem_addr: got %0d want 0", mem_addr); end
      checks++; if (mem_wdata !== '0)   begin errors++; $display("FAIL rst_mem_wdata: got %h want 0", mem_wdata); end
      checks++; if (cpu_hold !== 1'b0)  begin errors++; $display("FAIL rst_cpu_hold: got %b want 0", cpu_hold); end
      checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
      checks++; if (done !== 1'b0)      begin errors++; $display("FAIL rst_done: got %b want 0", done); end
      checks++; if (err !== 1'b0)       begin errors++; $display("FAIL rst_err: got %b want 0", err); end
      checks++; if (count !== '0)       begin errors++; $display("FAIL rst_count: got %0d want 0", count); end
      checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
   endtask

   task automatic test_basic();
      logic [31:0] want [3];
      want[0] = 32'h00500093; want[1] = 32'h002081B3; want[2] = 32'h402081B3;
      do_start();
      send_beat(4'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0);
      send_beat(4'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
      send_beat(4'd0, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
      checks++; if (cpu_hold !== 1'b1 || busy !== 1'b1) begin
         errors++; $display("FAIL basic_hold: cpu_hold=%b busy=%b want 1 1", cpu_hold, busy); end
      finish_wait(1'b1);
      checks++; if (obs_data.size() - obs_base !== 3) begin
         errors++; $display("FAIL basic_nwrites: got %0d want 3", obs_data.size() - obs_base); end
      for (int i = 0; i < 3 && obs_base + i < obs_data.size(); i++) begin
         checks++; if (obs_data[obs_base+i] !== want[i] || obs_addr[obs_base+i] !== ADDR_W'(i)) begin
            errors++; $display("FAIL basic_word%0d: got %h@%0d want %h@%0d", i, obs_data[obs_base+i], obs_addr[obs_base+i], want[i], i); end
      end
      checks++; if (done_cnt - done_base !== 1) begin
         errors++; $display("FAIL basic_done_pulses: got %0d want 1", done_cnt - done_base); end
      checks++; if (hold_at_done - hold_base !== 0) begin
         errors++; $display("FAIL basic_hold_at_done: cpu_hold high during done %0d times, want 0", hold_at_done - hold_base); end
      checks++; if (count !== 11'd3 || cpu_hold !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL basic_end: count=%0d hold=%b busy=%b want 3 0 0", count, cpu_hold, busy); end
   endtask

   task automatic test_formats();
      logic [31:0] want [4];
      want[0] = 32'h0020A423; want[1] = 32'hFE208EE3; want[2] = 32'h008000EF; want[3] = 32'h123452B7;
      do_start();
      send_beat(4'd3, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0);
      send_beat(4'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 1'b0);
      send_beat(4'd7, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8, 1'b0);
      send_beat(4'd5, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345000, 1'b1);
      finish_wait(1'b0);
      checks++; if (obs_data.size() - obs_base !== 4) begin
         errors++; $display("FAIL fmt_nwrites: got %0d want 4", obs_data.size() - obs_base); end
      for (int i = 0; i < 4 && obs_base + i < obs_data.size(); i++) begin
         checks++; if (obs_data[obs_base+i] !== want[i] || obs_addr[obs_base+i] !== ADDR_W'(i)) begin
            errors++; $display("FAIL fmt_word%0d: got %h@%0d want %h@%0d", i, obs_data[obs_base+i], obs_addr[obs_base+i], want[i], i); end
      end
   endtask

   task automatic test_stall();
      int ready_low = 0;
      stall_force = 1'b1;
      @(posedge clk); #1;
      do_start();
      fork
         begin
            logic [3:0] t; logic [2:0] f3; logic alt; logic [4:0] rd, rs1, rs2; logic [31:0] imm;
            for (int k = 0; k < 6; k++) begin
               rand_beat(1'b0, t, f3, alt, rd, rs1, rs2, imm);
               send_beat(t, f3, alt, rd, rs1, rs2, imm, 1'b0);
            end
         end
         begin
            bit have_ref = 1'b0;
            logic [ADDR_W-1:0] ra; logic [31:0] rdat;
            for (int k = 0; k < 8; k++) begin
               @(negedge clk);
               if (busy && !in_ready) ready_low++;
               if (mem_we) begin
                  if (!have_ref) begin have_ref = 1'b1; ra = mem_addr; rdat = mem_wdata; end
                  else begin
                     checks++; if (mem_addr !== ra || mem_wdata !== rdat) begin
                        errors++; $display("FAIL stall_hold: got %h@%0d want %h@%0d", mem_wdata, mem_addr, rdat, ra); end
                  end
               end
            end
            @(posedge clk); #1;
            stall_force = 1'b0;
         end
      join
      checks++; if (ready_low == 0) begin
         errors++; $display("FAIL stall_backpressure: in_ready low cycles %0d, want > 0", ready_low); end
      finish_wait(1'b1);
      checks++; if (obs_data.size() - obs_base !== 6) begin
         errors++; $display("FAIL stall_nwrites: got %0d want 6", obs_data.size() - obs_base); end
      for (int i = 0; i < exp_data.size() && obs_base + i < obs_data.size(); i++) begin
         checks++; if (obs_data[obs_base+i] !== exp_data[i] || obs_addr[obs_base+i] !== ADDR_W'(i)) begin
            errors++; $display("FAIL stall_word%0d: got %h@%0d want %h@%0d", i, obs_data[obs_base+i], obs_addr[obs_base+i], exp_data[i], i); end
      end
   endtask

   task automatic test_illegal();
      logic [32:0] r;
      do_start();
      send_beat(4'd12, 3'd0, 1'b0, 5'd1, 5'd1, 5'd1, 32'd0, 1'b0);
      finish_wait(1'b1);
      checks++; if (obs_data.size() - obs_base !== 0 || err !== 1'b1) begin
         errors++; $display("FAIL illegal_type: writes=%0d err=%b want 0 1", obs_data.size() - obs_base, err); end
      do_start();
      checks++; if (err !== 1'b0 || count !== '0) begin
         errors++; $display("FAIL start_clears: err=%b count=%0d want 0 0", err, count); end
      send_beat(4'd8, 3'd0, 1'b0, 5'd1, 5'd2, 5'd0, 32'd16, 1'b1);
      finish_wait(1'b0);
      r = ref_encode(4'd8, 3'd0, 1'b0, 5'd1, 5'd2, 5'd0, 32'd16);
      checks++; if (obs_data.size() - obs_base !== 1 || obs_addr[obs_data.size()-1] !== '0 || obs_data[obs_data.size()-1] !== r[31:0]) begin
         errors++; $display("FAIL restart_addr0: last %h@%0d want %h@0", obs_data[obs_data.size()-1], obs_addr[obs_data.size()-1], r[31:0]); end
   endtask

   task automatic test_random();
      logic [3:0] t; logic [2:0] f3; logic alt; logic [4:0] rd, rs1, rs2; logic [31:0] imm;
      stall_rand = 1'b1;
      for (int s = 0; s < 4; s++) begin
         int n = int'($urandom_range(8, 20));
         bit fin_with_beat = 1'($urandom_range(0, 1));
         do_start();
         for (int k = 0; k < n; k++) begin
            rand_beat(1'b1, t, f3, alt, rd, rs1, rs2, imm);
            send_beat(t, f3, alt, rd, rs1, rs2, imm, fin_with_beat && (k == n - 1));
         end
         finish_wait(!fin_with_beat);
         checks++; if (obs_data.size() - obs_base !== exp_data.size()) begin
            errors++; $display("FAIL rand%0d_nwrites: got %0d want %0d", s, obs_data.size() - obs_base, exp_data.size()); end
         for (int i = 0; i < exp_data.size() && obs_base + i < obs_data.size(); i++) begin
            checks++; if (obs_data[obs_base+i] !== exp_data[i] || obs_addr[obs_base+i] !== exp_addr[i]) begin
               errors++; $display("FAIL rand%0d_word%0d: got %h@%0d want %h@%0d", s, i, obs_data[obs_base+i], obs_addr[obs_base+i], exp_data[i], exp_addr[i]); end
         end
         checks++; if (err !== model_err || count !== 11'(model_count) || done_cnt - done_base !== 1 || hold_at_done != hold_base) begin
            errors++; $display("FAIL rand%0d_status: err=%b count=%0d dones=%0d want %b %0d 1", s, err, count, done_cnt - done_base, model_err, model_count); end
      end
      stall_rand = 1'b0;
   endtask

   task automatic test_wrap();
      logic [3:0] t; logic [2:0] f3; logic alt; logic [4:0] rd, rs1, rs2; logic [31:0] imm;
      int bad = 0;
      do_start();
      for (int k = 0; k < int'(MEM_WORDS) + 1; k++) begin
         rand_beat(1'b0, t, f3, alt, rd, rs1, rs2, imm);
         send_beat(t, f3, alt, rd, rs1, rs2, imm, 1'b0);
      end
      finish_wait(1'b1);
      checks++; if (obs_data.size() - obs_base !== exp_data.size()) begin
         errors++; $display("FAIL wrap_nwrites: got %0d want %0d", obs_data.size() - obs_base, exp_data.size()); end
      for (int i = 0; i < exp_data.size() && obs_base + i < obs_data.size(); i++)
         if (obs_data[obs_base+i] !== exp_data[i] || obs_addr[obs_base+i] !== exp_addr[i]) bad++;
      checks++; if (bad != 0) begin
         errors++; $display("FAIL wrap_words: %0d of %0d writes differ, want 0", bad, exp_data.size()); end
      checks++; if (obs_addr[obs_data.size()-1] !== '0 || err !== 1'b1 || count !== 11'(MEM_WORDS + 1)) begin
         errors++; $display("FAIL wrap_status: last_addr=%0d err=%b count=%0d want 0 1 %0d", obs_addr[obs_data.size()-1], err, count, MEM_WORDS + 1); end
   endtask

   task automatic test_reset_drain();
      logic [3:0] t; logic [2:0] f3; logic alt; logic [4:0] rd, rs1, rs2; logic [31:0] imm;
      int we_base, dn_base;
      stall_force = 1'b1;
      @(posedge clk); #1;
      do_start();
      for (int k = 0; k < 3; k++) begin
         rand_beat(1'b0, t, f3, alt, rd, rs1, rs2, imm);
         send_beat(t, f3, alt, rd, rs1, rs2, imm, k == 2);
      end
      checks++; if (busy !== 1'b1 || mem_we !== 1'b1 || in_ready !== 1'b0) begin
         errors++; $display("FAIL drain_state: busy=%b mem_we=%b in_ready=%b want 1 1 0", busy, mem_we, in_ready); end
      @(negedge clk); #2;
      rst = 1'b1;
      #1;
      test_reset();
      we_base = we_cnt;
      dn_base = done_cnt;
      stall_force = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      checks++; if (we_cnt !== we_base || done_cnt !== dn_base || busy !== 1'b0) begin
         errors++; $display("FAIL post_reset_quiet: we_cycles=%0d dones=%0d busy=%b want 0 0 0", we_cnt - we_base, done_cnt - dn_base, busy); end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      rst = 1'b0;
      @(posedge clk); #1;
      test_reset();
      test_basic();
      test_formats();
      test_stall();
      test_illegal();
      test_random();
      test_wrap();
      test_reset_drain();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
